l15_fetch_responder: RTL and testbench

//  Responder end of the transducer<->L1.5 interface, acting as a cache-side model for the fetch stage.

---
 rtl/l15_fetch_responder.sv | 185 ++++++++++++++++++
 tb/tb_l15_fetch_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l15_fetch_responder.sv
// l15_fetch_responder: cache-side stand-in for the L1.5 seen by the fetch transducer.
// Serves 128-bit lines and 32-bit stores from a word RAM after a fixed latency, plus a wake-up interrupt.
module l15_fetch_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned RESP_LAT  = 2,
  parameter int unsigned WAKE_DLY  = 4,
  parameter bit          ACK_SPLIT = 1'b0,
  localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          transducer_l15_val,
  input  logic [4:0]    transducer_l15_rqtype,
  input  logic [2:0]    transducer_l15_size,
  input  logic [31:0]   transducer_l15_address,
  input  logic [63:0]   transducer_l15_data,
  output logic          l15_transducer_header_ack,
  output logic          l15_transducer_ack,
  output logic          l15_transducer_val,
  output logic [3:0]    l15_transducer_returntype,
  output logic [63:0]   l15_transducer_data_0,
  output logic [63:0]   l15_transducer_data_1,
  input  logic          transducer_l15_req_ack,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [31:0]   mem_wdata
);

  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic [2:0] {
    S_WAKE,
    S_INTR,
    S_IDLE,
    S_ACKW,
    S_LAT,
    S_RESP
  } state_t;

  state_t        state;
  logic [15:0]   cnt;
  logic          ack_q;
  logic [4:0]    rq_type;
  logic [31:0]   rq_addr;
  logic [31:0]   rq_wdata;

  logic [31:0]   mem [MEM_WORDS];

  logic [4:0]    cur_type;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [31:0]   cur_off;
  logic [AW-1:0] cur_word;
  logic [AW-1:0] line_base;
  logic          cur_err;
  logic          cur_is_store;
  logic          accept;
  logic          finish;
  logic          store_we;
  logic [31:0]   rword [4];
  logic [3:0]    resp_rt;
  logic [63:0]   resp_d0;
  logic [63:0]   resp_d1;
  logic          unused_ok;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // In the accept cycle the request has not been latched yet, so decode straight from the inputs.
  assign cur_type     = (state == S_IDLE) ? transducer_l15_rqtype       : rq_type;
  assign cur_addr     = (state == S_IDLE) ? transducer_l15_address      : rq_addr;
  assign cur_wdata    = (state == S_IDLE) ? transducer_l15_data[31:0]   : rq_wdata;
  assign cur_off      = cur_addr - BASE_ADDR;
  assign cur_word     = cur_off[AW+1:2];
  assign line_base    = {cur_word[AW-1:2], 2'b00};
  assign cur_err      = ({1'b0, cur_off} >= MEM_BYTES) || (cur_type > 5'd1);
  assign cur_is_store = (cur_type == 5'd1);

  assign accept   = (state == S_IDLE) && transducer_l15_val && !rst;
  assign finish   = ((state == S_IDLE) && transducer_l15_val && !ACK_SPLIT && (RESP_LAT <= 1)) ||
                    (((state == S_ACKW) || (state == S_LAT)) && (cnt <= 16'd1));
  assign store_we = finish && !rst && cur_is_store && !cur_err &&
                    !(mem_we && (mem_waddr == cur_word));

  assign l15_transducer_header_ack = accept;
  assign l15_transducer_ack        = ack_q || (accept && !ACK_SPLIT);
  assign unused_ok = ^{transducer_l15_size, transducer_l15_data[63:32]};

  // Line words bypass a same-cycle backdoor write so the new word is returned.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rword[k] = (mem_we && (mem_waddr == (line_base | AW'(k)))) ? mem_wdata
                                                                 : mem[line_base | AW'(k)];
    end
  end

  always_comb begin
    resp_rt = 4'b0000;
    resp_d0 = '0;
    resp_d1 = '0;
    if (cur_err) begin
      resp_rt = 4'b1100;
    end else if (cur_is_store) begin
      resp_rt = 4'b0100;
    end else begin
      resp_d0 = {bswap(rword[0]), bswap(rword[1])};
      resp_d1 = {bswap(rword[2]), bswap(rword[3])};
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (store_we) begin
      mem[cur_word] <= bswap(cur_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= S_WAKE;
      cnt                       <= '0;
      ack_q                     <= 1'b0;
      rq_type                   <= '0;
      rq_addr                   <= '0;
      rq_wdata                  <= '0;
      l15_transducer_val        <= 1'b0;
      l15_transducer_returntype <= '0;
      l15_transducer_data_0     <= '0;
      l15_transducer_data_1     <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        S_WAKE: begin
          if (32'(cnt) + 32'd1 >= WAKE_DLY) begin
            state                     <= S_INTR;
            cnt                       <= '0;
            l15_transducer_val        <= 1'b1;
            l15_transducer_returntype <= 4'b0111;
            l15_transducer_data_0     <= '0;
            l15_transducer_data_1     <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_INTR, S_RESP: begin
          if (transducer_l15_req_ack) begin
            state                     <= S_IDLE;
            l15_transducer_val        <= 1'b0;
            l15_transducer_returntype <= '0;
            l15_transducer_data_0     <= '0;
            l15_transducer_data_1     <= '0;
          end
        end
        S_IDLE: begin
          if (transducer_l15_val) begin
            rq_type  <= transducer_l15_rqtype;
            rq_addr  <= transducer_l15_address;
            rq_wdata <= transducer_l15_data[31:0];
            cnt      <= 16'(RESP_LAT - 1);
            ack_q    <= ACK_SPLIT;
            state    <= ACK_SPLIT ? S_ACKW : S_LAT;
          end
        end
        S_ACKW, S_LAT: begin
          cnt   <= cnt - 16'd1;
          state <= S_LAT;
        end
        default: state <= S_WAKE;
      endcase
      // Entering RESP overrides whatever the case chose for this cycle.
      if (finish) begin
        state                     <= S_RESP;
        l15_transducer_val        <= 1'b1;
        l15_transducer_returntype <= resp_rt;
        l15_transducer_data_0     <= resp_d0;
        l15_transducer_data_1     <= resp_d1;
      end
    end
  end

endmodule

// File: tb/tb_l15_fetch_responder.sv
// Self-checking bench for l15_fetch_responder: two instances (ack split off/on) share stimulus
// and are compared against a word-array reference model of the L1.5 responder.
module tb_l15_fetch_responder;

  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h4000_0000;
  localparam int          RESP_LAT  = 2;
  localparam int          WAKE_DLY  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_val = 1'b0;
  logic [4:0]  rqtype = '0;
  logic [2:0]  size = '0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        req_ack = 1'b0;
  logic        mem_we = 1'b0;
  logic [9:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;

  logic        hack0, ack0, val0, hack1, ack1, val1;
  logic [3:0]  rt0, rt1;
  logic [63:0] d00, d10, d01, d11;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [MEM_WORDS];

  always #5 clk = ~clk;

  l15_fetch_responder #(
    .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .RESP_LAT(RESP_LAT), .WAKE_DLY(WAKE_DLY), .ACK_SPLIT(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .transducer_l15_val(req_val), .transducer_l15_rqtype(rqtype), .transducer_l15_size(size),
    .transducer_l15_address(addr), .transducer_l15_data(wdata),
    .l15_transducer_header_ack(hack0), .l15_transducer_ack(ack0), .l15_transducer_val(val0),
    .l15_transducer_returntype(rt0), .l15_transducer_data_0(d00), .l15_transducer_data_1(d10),
    .transducer_l15_req_ack(req_ack), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  l15_fetch_responder #(
    .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .RESP_LAT(RESP_LAT), .WAKE_DLY(WAKE_DLY), .ACK_SPLIT(1'b1)
  ) u_split (
    .clk(clk), .rst(rst),
    .transducer_l15_val(req_val), .transducer_l15_rqtype(rqtype), .transducer_l15_size(size),
    .transducer_l15_address(addr), .transducer_l15_data(wdata),
    .l15_transducer_header_ack(hack1), .l15_transducer_ack(ack1), .l15_transducer_val(val1),
    .l15_transducer_returntype(rt1), .l15_transducer_data_0(d01), .l15_transducer_data_1(d11),
    .transducer_l15_req_ack(req_ack), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic bit is_err(input logic [4:0] t, input logic [31:0] a);
    return (t > 5'd1) || (a < BASE) || (a >= BASE + 32'(4 * MEM_WORDS));
  endfunction

  task automatic bd_write(input int idx, input logic [31:0] data);
    @(negedge clk);
    req_val = 1'b0; req_ack = 1'b0;
    mem_we = 1'b1; mem_waddr = 10'(idx); mem_wdata = data;
    ref_mem[idx] = data;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      mem_we = 1'b0; req_val = 1'b0; req_ack = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if ({hack0, ack0, val0, hack1, ack1, val1} !== 6'b0) begin
        miscompares++;
        $display("[TB] FAIL idle: got hack/ack/val=%b%b%b %b%b%b, want all 0",
                 hack0, ack0, val0, hack1, ack1, val1);
      end
    end
    req_ack = 1'b0;
  endtask

  // One request; optional backdoor write in the cycle after accept; response held `hold` cycles before req_ack.
  task automatic do_req(input logic [4:0] t, input logic [31:0] a, input logic [31:0] w, input int hold,
                        input bit bd_en, input int bd_idx, input logic [31:0] bd_data);
    logic [3:0]  exp_rt;
    logic [63:0] exp_d0, exp_d1;
    int          widx, lidx;
    @(negedge clk);
    mem_we = 1'b0; req_ack = 1'b0;
    req_val = 1'b1; rqtype = t; addr = a; wdata = {$urandom, w}; size = 3'($urandom);
    #1;
    vectors++;
    if ({hack0, ack0, val0, hack1, ack1, val1} !== 6'b110_100) begin
      miscompares++;
      $display("[TB] FAIL accept a=%h: got hack/ack/val=%b%b%b split=%b%b%b, want 110 100",
               a, hack0, ack0, val0, hack1, ack1, val1);
    end
    @(negedge clk);
    req_val = 1'($urandom_range(0, 1)); rqtype = 5'($urandom); addr = $urandom;
    mem_we = bd_en; mem_waddr = 10'(bd_idx); mem_wdata = bd_data;
    #1;
    vectors++;
    if ({hack0, ack0, val0, hack1, ack1, val1} !== 6'b000_010) begin
      miscompares++;
      $display("[TB] FAIL ack_split a=%h: got hack/ack/val=%b%b%b split=%b%b%b, want 000 010",
               a, hack0, ack0, val0, hack1, ack1, val1);
    end
    if (bd_en) ref_mem[bd_idx] = bd_data;
    widx = int'((a - BASE) >> 2);
    exp_d0 = '0;
    exp_d1 = '0;
    if (is_err(t, a)) begin
      exp_rt = 4'b1100;
    end else if (t == 5'd1) begin
      exp_rt = 4'b0100;
      if (!(bd_en && bd_idx == widx)) ref_mem[widx] = swap32(w);
    end else begin
      exp_rt = 4'b0000;
      lidx   = widx & ~3;
      exp_d0 = {swap32(ref_mem[lidx]), swap32(ref_mem[lidx + 1])};
      exp_d1 = {swap32(ref_mem[lidx + 2]), swap32(ref_mem[lidx + 3])};
    end
    for (int c = 2; c < RESP_LAT; c++) begin
      @(negedge clk);
      mem_we = 1'b0;
      #1;
      vectors++;
      if ({val0, val1} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL latency a=%h: got val=%b%b, want 00", a, val0, val1);
      end
    end
    for (int c = 0; c <= hold; c++) begin
      @(negedge clk);
      mem_we = 1'b0; req_ack = (c == hold);
      req_val = 1'($urandom_range(0, 1)); rqtype = 5'($urandom); addr = $urandom;
      #1;
      vectors++;
      if ({val0, rt0, d00, d10} !== {1'b1, exp_rt, exp_d0, exp_d1}) begin
        miscompares++;
        $display("[TB] FAIL resp t=%0d a=%h cyc=%0d: got val=%b rt=%b d0=%h d1=%h, want rt=%b d0=%h d1=%h",
                 t, a, c, val0, rt0, d00, d10, exp_rt, exp_d0, exp_d1);
      end
      vectors++;
      if ({val1, rt1, d01, d11} !== {1'b1, exp_rt, exp_d0, exp_d1}) begin
        miscompares++;
        $display("[TB] FAIL resp_split t=%0d a=%h cyc=%0d: got val=%b rt=%b d0=%h d1=%h, want rt=%b d0=%h d1=%h",
                 t, a, c, val1, rt1, d01, d11, exp_rt, exp_d0, exp_d1);
      end
      vectors++;
      if ({hack0, ack0, hack1, ack1} !== 4'b0) begin
        miscompares++;
        $display("[TB] FAIL no_ack_in_resp: got hack/ack=%b%b %b%b, want 0000", hack0, ack0, hack1, ack1);
      end
    end
  endtask

  // Reset for one clock, then WAKE_DLY quiet cycles (requests ignored) and a wake interrupt acked on its 3rd cycle.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_val = 1'b0; req_ack = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    rst = 1'b0; req_val = 1'b1; rqtype = 5'd0; addr = BASE;
    #1;
    vectors++;
    if ({hack0, ack0, val0, rt0, d00, d10, hack1, ack1, val1, rt1, d01, d11} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got val=%b rt=%b d0=%h hack=%b ack=%b, want all 0",
               val0, rt0, d00, hack0, ack0);
    end
    for (int c = 1; c < WAKE_DLY; c++) begin
      @(negedge clk);
      #1;
      vectors++;
      if ({hack0, ack0, val0, hack1, ack1, val1} !== 6'b0) begin
        miscompares++;
        $display("[TB] FAIL wake cyc=%0d: got hack/ack/val=%b%b%b %b%b%b, want all 0",
                 c, hack0, ack0, val0, hack1, ack1, val1);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_val = 1'b0; req_ack = (c == 2);
      #1;
      vectors++;
      if ({val0, rt0, d00, d10, val1, rt1, d01, d11} !== {1'b1, 4'b0111, 128'b0, 1'b1, 4'b0111, 128'b0}) begin
        miscompares++;
        $display("[TB] FAIL intr cyc=%0d: got val=%b%b rt=%b %b d0=%h, want val=11 rt=0111 data=0",
                 c, val0, val1, rt0, rt1, d00);
      end
    end
    @(negedge clk);
    req_ack = 1'b0;
    #1;
    vectors++;
    if ({val0, val1} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL intr_release: got val=%b%b, want 00", val0, val1);
    end
  endtask

  task automatic test_spec_load();
    for (int i = 0; i < 4; i++) bd_write(i, 32'h0000_0013);
    do_req(5'd0, 32'h4000_0008, 32'h0, 0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_random_loads();
    for (int i = 0; i < 20; i++) begin
      do_req(5'd0, BASE + 32'($urandom_range(0, 4 * MEM_WORDS - 1)), $urandom,
             $urandom_range(0, 3), 1'b0, 0, 32'h0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
  endtask

  task automatic test_store();
    do_req(5'd1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 1'b0, 0, 32'h0);
    do_req(5'd0, 32'h4000_0010, 32'h0, 0, 1'b0, 0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = BASE + 32'($urandom_range(0, 4 * MEM_WORDS - 1));
      do_req(5'd1, a, $urandom, 0, 1'b0, 0, 32'h0);
      do_req(5'd0, a, $urandom, 1, 1'b0, 0, 32'h0);
    end
  endtask

  task automatic test_errors();
    do_req(5'd0, 32'h3FFF_FFFC, 32'h0, 0, 1'b0, 0, 32'h0);
    do_req(5'd5, 32'h4000_0020, 32'h1234_5678, 0, 1'b0, 0, 32'h0);
    do_req(5'd1, 32'h4000_1000, 32'hCAFE_F00D, 0, 1'b0, 0, 32'h0);
    do_req(5'd1, 32'h3FFF_FFFC, 32'hCAFE_F00D, 0, 1'b0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      do_req(5'($urandom_range(2, 31)), BASE + 32'($urandom_range(0, 4 * MEM_WORDS - 1)),
             $urandom, 0, 1'b0, 0, 32'h0);
    end
    do_req(5'd0, 32'h4000_0020, 32'h0, 0, 1'b0, 0, 32'h0);
    do_req(5'd0, 32'h4000_0FF0, 32'h0, 0, 1'b0, 0, 32'h0);
    do_req(5'd0, 32'h4000_0000, 32'h0, 0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_hold();
    do_req(5'd0, BASE + 32'($urandom_range(0, 4 * MEM_WORDS - 1)), 32'h0, 10, 1'b0, 0, 32'h0);
    do_req(5'd1, BASE + 32'h40, $urandom, 10, 1'b0, 0, 32'h0);
  endtask

  task automatic test_collision();
    do_req(5'd0, BASE + 32'h100, 32'h0, 0, 1'b1, 65, 32'hA5A5_0001);
    do_req(5'd1, BASE + 32'h200, 32'h1111_2222, 0, 1'b1, 128, 32'h3333_4444);
    do_req(5'd0, BASE + 32'h200, 32'h0, 0, 1'b0, 0, 32'h0);
    do_req(5'd1, BASE + 32'h300, 32'h5555_6666, 0, 1'b1, 193, 32'h7777_8888);
    do_req(5'd0, BASE + 32'h300, 32'h0, 0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      logic [4:0] t;
      t = ($urandom_range(0, 2) == 0) ? 5'd1 : 5'd0;
      do_req(t, BASE + 32'($urandom_range(0, 255)), $urandom, 0, 1'b0, 0, 32'h0);
    end
  endtask

  // A store is accepted, then reset lands in its latency cycle: the store must never reach the RAM.
  task automatic test_reset_mid();
    @(negedge clk);
    mem_we = 1'b0; req_ack = 1'b0;
    req_val = 1'b1; rqtype = 5'd1; addr = BASE + 32'h80; wdata = 64'h0000_0000_BAD0_BAD0;
    #1;
    vectors++;
    if ({hack0, ack0} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL mid_accept: got hack/ack=%b%b, want 11", hack0, ack0);
    end
    test_reset();
    do_req(5'd0, BASE + 32'h80, 32'h0, 0, 1'b0, 0, 32'h0);
  endtask

  initial begin
    $display("[TB] starting l15_fetch_responder bench");
    test_reset();
    for (int i = 0; i < MEM_WORDS; i++) bd_write(i, $urandom);
    idle(2);
    test_spec_load();
    test_random_loads();
    test_store();
    test_errors();
    test_hold();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400_000;
    $display("[TB] FAIL watchdog: got no end of test, want completion within bound");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
